commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Synthesisable capture buffer for writeback-stage commit events (pc, write enable, destination, data) of the pipelined core.
- Sits beside the core wrapper; the bench or a debug port drains it through a valid/ready interface.
- Replaces ad-hoc per-cycle trace printing: commits are buffered with parametrised width and depth, optional register-write filtering and a selectable overflow policy.

Parameters:
- PC_W, 32, program counter width
- DATA_W, 32, writeback data width
- DEPTH, 16, entries; power of two, >= 2
- WRITES_ONLY, 0, 1 = record only commits with w_enable_i=1
- DROP_OLDEST, 0, overflow policy: 0 = drop incoming, 1 = overwrite oldest

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous active-low reset
- w_valid_i  input  1  an instruction retires this cycle
- w_pc_i  input  PC_W  retiring pc
- w_enable_i  input  1  register write enable
- w_dest_i  input  5  destination register
- w_data_i  input  DATA_W  writeback data
- flush_i  input  1  synchronous buffer clear
- out_valid_o  output  1  head entry available
- out_ready_i  input  1  consumer accepts head
- out_pc_o / out_enable_o / out_dest_o / out_data_o  output  PC_W/1/5/DATA_W  head entry fields
- count_o  output  $clog2(DEPTH)+1  occupancy
- full_o, empty_o  output  1  status
- drop_cnt_o  output  16  saturating overflow counter

Behaviour:
- reset low: pointers, count_o, drop_cnt_o = 0; out_valid_o=0, empty_o=1, full_o=0; out_* fields = 0 while empty. Takes effect immediately and mid-operation; buffered entries are lost.
- qualify = w_valid_i && (!WRITES_ONLY || w_enable_i).
- pop = out_valid_o && out_ready_i.
- First-word-fall-through: out_* is driven combinationally from the head entry.
- Latency: a push at edge N is visible on out_valid_o and out_* in the cycle after edge N.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit. full_o = indices equal and wrap bits differ; empty_o = pointers equal. Natural wrap, no modulo logic.
- Push with count < DEPTH: the entry is written.
- Push while full with a simultaneous pop: accepted, count unchanged, no drop.
- Push while full without pop, DROP_OLDEST=0: incoming entry discarded; drop_cnt_o += 1.
- Push while full without pop, DROP_OLDEST=1: oldest entry overwritten; read and write pointers both advance; count stays DEPTH; drop_cnt_o += 1.
- Push while empty with out_ready_i=1: no pop that cycle (out_valid_o=0); the entry is stored.
- drop_cnt_o saturates at 16'hFFFF.
- flush_i: pointers and count clear next edge; any same-cycle push is ignored. drop_cnt_o is cleared only by reset.
- out_* is stable while out_valid_o=1 and out_ready_i=0, except under DROP_OLDEST overwrite when full.

Optional Feature:
- Macro TRACE_SEQ_EN.
- Defined: adds output out_seq_o (32 bits), a stamp taken from a 32-bit sequence counter at push time. The counter increments on every qualified commit, including dropped ones, so gaps in out_seq_o reveal losses. Counter resets to 0 and is not cleared by flush_i.
- Not defined: port, counter and storage bits are absent.

Decomposition:
- Package trace_pkg:
  - REG_ADDR_W = 5
  - trace_rec_t packed struct {pc, enable, dest, data}, sized from package parameters
  - DROP_CNT_W = 16
- One sub-module, trace_fifo_mem: DEPTH x record-width register array, one synchronous write port and one asynchronous read port; no reset on the array.

Test Plan:
- Reset: reset low mid-stream with count_o=5 -> count_o=0, out_valid_o=0, drop_cnt_o=0 immediately.
- Basic ordering: push pc=0x01000000, 0x01000004, 0x01000008 (dest 1,2,3, data 0xA,0xB,0xC) with out_ready_i=0, then hold ready=1 -> three pops in order; count_o sequence 3,2,1,0.
- Overflow, DROP_OLDEST=0, DEPTH=4: push 6 entries with no pops -> full_o=1; head pc stays the first entry; drop_cnt_o=2.
- Overflow, DROP_OLDEST=1, DEPTH=4: push 6 entries with no pops -> head is the 3rd entry; drop_cnt_o=2; count_o=4.
- Concurrent push/pop when full: push and pop every cycle for 10 cycles -> count_o stays 4, drop_cnt_o=0, entries leave in order.
- Filter and flush: with WRITES_ONLY=1, 4 commits alternating w_enable_i 1/0 -> 2 entries stored. flush_i with a concurrent push -> count_o=0 next cycle. With TRACE_SEQ_EN defined and DEPTH=4, 6 pushes and no pops under DROP_OLDEST=0 -> stored stamps 0,1,2,3; the next commit, drained after the buffer empties, reads 6.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace buffer.
// Optional build macro TRACE_SEQ_EN adds a 32-bit per-entry sequence stamp.
package trace_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DROP_CNT_W = 16;
    localparam int SEQ_W      = 32;

    // Default field widths; the top module may be built with other widths.
    localparam int TRC_PC_W   = 32;
    localparam int TRC_DATA_W = 32;

    typedef struct packed {
        logic [TRC_PC_W-1:0]   pc;
        logic                  enable;
        logic [REG_ADDR_W-1:0] dest;
        logic [TRC_DATA_W-1:0] data;
    } trace_rec_t;

    // Width of one packed commit record (pc, enable, dest, data) for given widths.
    function automatic int trace_rec_width(input int pc_w, input int data_w);
        return pc_w + 1 + REG_ADDR_W + data_w;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Storage array for the trace buffer: one synchronous write port, one
// asynchronous read port. The array is deliberately not reset; validity is
// tracked by the pointers in the parent.
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 70
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the incoming record at the write index.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures writeback commit events into a first-word-
// fall-through FIFO drained through a valid/ready port.
// Optional build macro TRACE_SEQ_EN adds out_seq_o, a stamp from a commit
// sequence counter that also advances on dropped commits, so gaps show losses.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WRITES_ONLY = 0,
    parameter int DROP_OLDEST = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_valid_i,
    input  logic [PC_W-1:0]          w_pc_i,
    input  logic                     w_enable_i,
    input  logic [REG_ADDR_W-1:0]    w_dest_i,
    input  logic [DATA_W-1:0]        w_data_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PC_W-1:0]          out_pc_o,
    output logic                     out_enable_o,
    output logic [REG_ADDR_W-1:0]    out_dest_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DROP_CNT_W-1:0]    drop_cnt_o
`ifdef TRACE_SEQ_EN
    ,
    output logic [SEQ_W-1:0]         out_seq_o
`endif
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int BASE_W = trace_rec_width(PC_W, DATA_W);
`ifdef TRACE_SEQ_EN
    localparam int REC_W  = BASE_W + SEQ_W;
`else
    localparam int REC_W  = BASE_W;
`endif

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic             w_qualify;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_write;
    logic             w_drop;
    logic [REC_W-1:0] w_wr_rec;
    logic [REC_W-1:0] w_rd_rec;
    logic [REC_W-1:0] w_head;

    assign w_qualify = w_valid_i && ((WRITES_ONLY == 0) || w_enable_i);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop     = !w_empty && out_ready_i;

    // A full buffer accepts a push only if a pop frees a slot the same cycle,
    // or if overwriting the oldest entry is the chosen overflow policy.
    assign w_drop    = w_qualify && !flush_i && w_full && !w_pop;
    assign w_write   = w_qualify && !flush_i &&
                       (!w_full || w_pop || (DROP_OLDEST != 0));

`ifdef TRACE_SEQ_EN
    logic [SEQ_W-1:0] r_seq;

    // Sequence counter advances on every qualified commit, stored or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seq <= '0;
        end else if (w_qualify) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    assign w_wr_rec = {r_seq, w_pc_i, w_enable_i, w_dest_i, w_data_i};
`else
    assign w_wr_rec = {w_pc_i, w_enable_i, w_dest_i, w_data_i};
`endif

    // Pointer update; under overwrite-oldest the read pointer follows the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop || (w_drop && (DROP_OLDEST != 0))) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Saturating overflow counter; survives flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_write),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_rec),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_rec)
    );

    // Head fields read as zero while empty so stale array contents never leak.
    assign w_head       = w_empty ? '0 : w_rd_rec;
    assign out_valid_o  = !w_empty;
    assign out_data_o   = w_head[DATA_W-1:0];
    assign out_dest_o   = w_head[DATA_W +: REG_ADDR_W];
    assign out_enable_o = w_head[DATA_W + REG_ADDR_W];
    assign out_pc_o     = w_head[DATA_W + REG_ADDR_W + 1 +: PC_W];
`ifdef TRACE_SEQ_EN
    assign out_seq_o    = w_head[BASE_W +: SEQ_W];
`endif

    assign count_o    = r_wr_ptr - r_rd_ptr;
    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer. Four instances share
// one stimulus stream: a (DEPTH 16), b (DEPTH 4, drop incoming),
// c (DEPTH 4, overwrite oldest), d (DEPTH 4, register writes only).
module tb_commit_trace_buffer;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_valid = 1'b0;
    logic [31:0] w_pc = '0;
    logic        w_en = 1'b0;
    logic [4:0]  w_dest = '0;
    logic [31:0] w_data = '0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;

    logic        v_a, v_b, v_c, v_d;
    logic [31:0] pc_a, pc_b, pc_c, pc_d;
    logic        en_a, en_b, en_c, en_d;
    logic [4:0]  dst_a, dst_b, dst_c, dst_d;
    logic [31:0] dat_a, dat_b, dat_c, dat_d;
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b, cnt_c, cnt_d;
    logic        full_a, full_b, full_c, full_d;
    logic        emp_a, emp_b, emp_c, emp_d;
    logic [15:0] drp_a, drp_b, drp_c, drp_d;
`ifdef TRACE_SEQ_EN
    logic [31:0] seq_a, seq_b, seq_c, seq_d;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    trace_rec_t q_a[$];
    trace_rec_t q_b[$];
    trace_rec_t q_c[$];

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(16), .WRITES_ONLY(0), .DROP_OLDEST(0)) dut_a (
        .clk(clk), .reset(reset), .w_valid_i(w_valid), .w_pc_i(w_pc), .w_enable_i(w_en),
        .w_dest_i(w_dest), .w_data_i(w_data), .flush_i(flush), .out_valid_o(v_a),
        .out_ready_i(ready), .out_pc_o(pc_a), .out_enable_o(en_a), .out_dest_o(dst_a),
        .out_data_o(dat_a), .count_o(cnt_a), .full_o(full_a), .empty_o(emp_a),
        .drop_cnt_o(drp_a)
`ifdef TRACE_SEQ_EN
        , .out_seq_o(seq_a)
`endif
    );

    commit_trace_buffer #(.DEPTH(4), .WRITES_ONLY(0), .DROP_OLDEST(0)) dut_b (
        .clk(clk), .reset(reset), .w_valid_i(w_valid), .w_pc_i(w_pc), .w_enable_i(w_en),
        .w_dest_i(w_dest), .w_data_i(w_data), .flush_i(flush), .out_valid_o(v_b),
        .out_ready_i(ready), .out_pc_o(pc_b), .out_enable_o(en_b), .out_dest_o(dst_b),
        .out_data_o(dat_b), .count_o(cnt_b), .full_o(full_b), .empty_o(emp_b),
        .drop_cnt_o(drp_b)
`ifdef TRACE_SEQ_EN
        , .out_seq_o(seq_b)
`endif
    );

    commit_trace_buffer #(.DEPTH(4), .WRITES_ONLY(0), .DROP_OLDEST(1)) dut_c (
        .clk(clk), .reset(reset), .w_valid_i(w_valid), .w_pc_i(w_pc), .w_enable_i(w_en),
        .w_dest_i(w_dest), .w_data_i(w_data), .flush_i(flush), .out_valid_o(v_c),
        .out_ready_i(ready), .out_pc_o(pc_c), .out_enable_o(en_c), .out_dest_o(dst_c),
        .out_data_o(dat_c), .count_o(cnt_c), .full_o(full_c), .empty_o(emp_c),
        .drop_cnt_o(drp_c)
`ifdef TRACE_SEQ_EN
        , .out_seq_o(seq_c)
`endif
    );

    commit_trace_buffer #(.DEPTH(4), .WRITES_ONLY(1), .DROP_OLDEST(0)) dut_d (
        .clk(clk), .reset(reset), .w_valid_i(w_valid), .w_pc_i(w_pc), .w_enable_i(w_en),
        .w_dest_i(w_dest), .w_data_i(w_data), .flush_i(flush), .out_valid_o(v_d),
        .out_ready_i(ready), .out_pc_o(pc_d), .out_enable_o(en_d), .out_dest_o(dst_d),
        .out_data_o(dat_d), .count_o(cnt_d), .full_o(full_d), .empty_o(emp_d),
        .drop_cnt_o(drp_d)
`ifdef TRACE_SEQ_EN
        , .out_seq_o(seq_d)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic head_chk(input string tag, input logic v, input logic [31:0] pc,
                            input logic en, input logic [4:0] dest, input logic [31:0] data,
                            input trace_rec_t exp);
        chk({tag, ".valid"}, 64'(v), 64'd1);
        chk({tag, ".pc"}, 64'(pc), 64'(exp.pc));
        chk({tag, ".en"}, 64'(en), 64'(exp.enable));
        chk({tag, ".dest"}, 64'(dest), 64'(exp.dest));
        chk({tag, ".data"}, 64'(data), 64'(exp.data));
    endtask

    function automatic trace_rec_t mk(input logic [31:0] pc, input logic en,
                                      input logic [4:0] dest, input logic [31:0] data);
        trace_rec_t r;
        r.pc = pc; r.enable = en; r.dest = dest; r.data = data;
        return r;
    endfunction

    task automatic drive(input trace_rec_t r);
        w_valid = 1'b1; w_pc = r.pc; w_en = r.enable; w_dest = r.dest; w_data = r.data;
    endtask

    task automatic idle();
        w_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        trace_rec_t r;

        // Reset state
        step(); step();
        chk("rst.valid", 64'(v_a), 64'd0);
        chk("rst.empty", 64'(emp_a), 64'd1);
        chk("rst.full", 64'(full_a), 64'd0);
        chk("rst.count", 64'(cnt_a), 64'd0);
        chk("rst.pc", 64'(pc_a), 64'd0);
        chk("rst.drop", 64'(drp_a), 64'd0);
        reset = 1'b1;
        step();

        // Reset asserted mid-stream takes effect without a clock edge
        for (int i = 0; i < 5; i++) begin
            drive(mk(32'h2000 + 32'(4 * i), 1'b1, 5'(i), 32'(i)));
            step();
        end
        idle();
        chk("mid.count_before", 64'(cnt_a), 64'd5);
        chk("mid.drop_before", 64'(drp_b), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid.count", 64'(cnt_a), 64'd0);
        chk("mid.valid", 64'(v_a), 64'd0);
        chk("mid.empty", 64'(emp_a), 64'd1);
        chk("mid.drop", 64'(drp_b), 64'd0);
        step();
        reset = 1'b1;
        step();

        // Basic ordering and first-word-fall-through latency
        for (int i = 0; i < 3; i++) begin
            r = mk(32'h0100_0000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'hA + 32'(i));
            drive(r);
            q_a.push_back(r);
            step();
            chk("ord.valid_after_push", 64'(v_a), 64'd1);
        end
        idle();
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ord.count", 64'(cnt_a), 64'(3 - k));
            if (k < 3) head_chk("ord.head", v_a, pc_a, en_a, dst_a, dat_a, q_a[0]);
            step();
            if (k < 3) void'(q_a.pop_front());
        end
        chk("ord.valid_end", 64'(v_a), 64'd0);
        ready = 1'b0;

        // Overflow with both policies, DEPTH 4, six pushes, no pops
        do_reset();
        q_b.delete(); q_c.delete();
        for (int i = 0; i < 6; i++) begin
            r = mk(32'h100 + 32'(4 * i), 1'b1, 5'(i + 8), 32'h50 + 32'(i));
            drive(r);
            if (i < 4) q_b.push_back(r);
            if (i >= 2) q_c.push_back(r);
            step();
        end
        idle();
        chk("ovf0.full", 64'(full_b), 64'd1);
        chk("ovf0.head_pc", 64'(pc_b), 64'h100);
        chk("ovf0.drop", 64'(drp_b), 64'd2);
        chk("ovf0.count", 64'(cnt_b), 64'd4);
        chk("ovf1.full", 64'(full_c), 64'd1);
        chk("ovf1.head_pc", 64'(pc_c), 64'h108);
        chk("ovf1.drop", 64'(drp_c), 64'd2);
        chk("ovf1.count", 64'(cnt_c), 64'd4);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            head_chk("ovf0.drain", v_b, pc_b, en_b, dst_b, dat_b, q_b[0]);
            head_chk("ovf1.drain", v_c, pc_c, en_c, dst_c, dat_c, q_c[0]);
            step();
            void'(q_b.pop_front());
            void'(q_c.pop_front());
        end
        chk("ovf0.empty", 64'(emp_b), 64'd1);
        chk("ovf1.empty", 64'(emp_c), 64'd1);
        ready = 1'b0;

        // Concurrent push and pop while full
        do_reset();
        q_b.delete(); q_c.delete();
        for (int i = 0; i < 4; i++) begin
            r = mk(32'h3000 + 32'(4 * i), 1'b1, 5'(i), 32'h700 + 32'(i));
            drive(r);
            q_b.push_back(r);
            q_c.push_back(r);
            step();
        end
        chk("pp.full_start", 64'(full_b), 64'd1);
        ready = 1'b1;
        for (int i = 4; i < 14; i++) begin
            r = mk(32'h3000 + 32'(4 * i), i[0], 5'(i), 32'h700 + 32'(i));
            drive(r);
            head_chk("pp.b", v_b, pc_b, en_b, dst_b, dat_b, q_b[0]);
            head_chk("pp.c", v_c, pc_c, en_c, dst_c, dat_c, q_c[0]);
            step();
            void'(q_b.pop_front());
            void'(q_c.pop_front());
            q_b.push_back(r);
            q_c.push_back(r);
            chk("pp.count_b", 64'(cnt_b), 64'd4);
            chk("pp.count_c", 64'(cnt_c), 64'd4);
        end
        idle();
        ready = 1'b0;
        chk("pp.drop_b", 64'(drp_b), 64'd0);
        chk("pp.drop_c", 64'(drp_c), 64'd0);

        // Write-only filter, then flush with a concurrent push
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(mk(32'h4000 + 32'(4 * i), (i % 2 == 0), 5'(i), 32'(i)));
            step();
        end
        idle();
        chk("flt.count_d", 64'(cnt_d), 64'd2);
        chk("flt.count_a", 64'(cnt_a), 64'd4);
        chk("flt.head_d", 64'(pc_d), 64'h4000);
        drive(mk(32'h4010, 1'b1, 5'd4, 32'd4));
        step();
        chk("flt.drop_b", 64'(drp_b), 64'd1);
        drive(mk(32'h4014, 1'b1, 5'd5, 32'd5));
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("fl.count_d", 64'(cnt_d), 64'd0);
        chk("fl.count_a", 64'(cnt_a), 64'd0);
        chk("fl.empty_a", 64'(emp_a), 64'd1);
        chk("fl.valid_b", 64'(v_b), 64'd0);
        chk("fl.pc_a", 64'(pc_a), 64'd0);
        chk("fl.drop_kept", 64'(drp_b), 64'd1);

`ifdef TRACE_SEQ_EN
        // Sequence stamps expose the dropped commits
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(mk(32'h5000 + 32'(4 * i), 1'b1, 5'(i), 32'(i)));
            step();
        end
        idle();
        chk("seq.drop", 64'(drp_b), 64'd2);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("seq.stamp", 64'(seq_b), 64'(k));
            step();
        end
        chk("seq.empty", 64'(emp_b), 64'd1);
        drive(mk(32'h6000, 1'b1, 5'd1, 32'd1));
        step();
        idle();
        chk("seq.next_valid", 64'(v_b), 64'd1);
        chk("seq.next_stamp", 64'(seq_b), 64'd6);
        step();
        chk("seq.empty_end", 64'(emp_b), 64'd1);
        ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
